// File: rtl/arb_pkg.sv
// Shared constants and helpers for the requester arbiter: scheme names,
// vector rotation and one-hot to binary conversion.
package arb_pkg;

  localparam string ARB_FP  = "FP";
  localparam string ARB_RR  = "RR";
  localparam string ARB_WRR = "WRR";

  // Helpers operate on a fixed wide container; arbiters must keep REQS < MAX_REQS.
  localparam int MAX_REQS = 64;
  localparam int IDX_W    = 7;

  function automatic logic [MAX_REQS-1:0] rotl(input logic [MAX_REQS-1:0] v,
                                                input int n);
    logic [MAX_REQS-1:0] mask;
    mask = (MAX_REQS'(1) << n) - MAX_REQS'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic logic [IDX_W-1:0] onehot2binary(input logic [MAX_REQS-1:0] v);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_REQS; i++) begin
      if (v[i]) b = b | IDX_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wrr_arbitrator_if.sv
// Requester-side bundle of the arbiter: requests, transaction framing,
// weights and the resulting grant.
interface wrr_arbitrator_if #(
  parameter int REQS = 4,
  parameter int WW   = 4
);
  logic [REQS-1:0]         req;
  logic [REQS-1:0]         last;
  logic [REQS*WW-1:0]      weight;
  logic                    rdy;
  logic [REQS-1:0]         gnt;
  logic [$clog2(REQS)-1:0] num;
  logic                    lock;

  modport master (
    output req, last, weight, rdy,
    input  gnt, num, lock
  );

  modport slave (
    input  req, last, weight, rdy,
    output gnt, num, lock
  );
endinterface

// File: rtl/prio_select.sv
// Picks the first set request at or above the one-hot top position, wrapping
// around, by subtracting top from the request vector concatenated with itself.
module prio_select #(
  parameter int REQS = 4
) (
  input  logic [REQS-1:0] req,
  input  logic [REQS-1:0] top,
  output logic [REQS-1:0] gnt
);
  logic [2*REQS-1:0] dbl;
  logic [2*REQS-1:0] msk;

  assign dbl = {req, req};
  assign msk = dbl & ~(dbl - {{REQS{1'b0}}, top});
  assign gnt = msk[REQS-1:0] | msk[2*REQS-1:REQS];
endmodule

// File: rtl/wrr_arbitrator.sv
// Fixed-priority / round-robin / weighted round-robin arbiter with the grant
// held across multi-beat transactions framed by the owner's last flag.
module wrr_arbitrator
  import arb_pkg::*;
#(
  parameter int    REQS   = 4,
  parameter string SCHEME = "WRR",
  parameter int    WW     = 4
) (
  input logic             clk,
  input logic             reset,
  wrr_arbitrator_if.slave bus
);
  localparam int NW = $clog2(REQS);
  localparam bit IS_FP = (SCHEME == ARB_FP);
  localparam bit IS_RR = (SCHEME == ARB_RR);
  localparam logic [REQS-1:0] TOP_RST = {{(REQS-1){1'b0}}, 1'b1};
  localparam logic [WW:0]     ONE_C   = {{WW{1'b0}}, 1'b1};

  logic                lck_reg;
  logic [REQS-1:0]     own_reg;
  logic [REQS-1:0]     top_reg;
  logic [WW-1:0]       cnt_reg;

  logic [REQS-1:0]     top;
  logic [REQS-1:0]     act_gnt;
  logic [REQS-1:0]     gnt;
  logic [MAX_REQS-1:0] gnt_w;
  logic [MAX_REQS-1:0] rot_w;
  logic [IDX_W-1:0]    idx_w;
  logic [NW-1:0]       k;
  logic [WW-1:0]       w_k;
  logic [WW:0]         w_eff;
  logic [WW:0]         c;
  logic                beat;
  logic                eot;
  logic                advance;
  logic                unused_bits;

  assign top = IS_FP ? TOP_RST : top_reg;

  prio_select #(.REQS(REQS)) u_prio (
    .req (bus.req),
    .top (top),
    .gnt (act_gnt)
  );

  assign gnt   = lck_reg ? (own_reg & bus.req) : act_gnt;
  assign gnt_w = MAX_REQS'(gnt);
  assign idx_w = onehot2binary(gnt_w);
  assign k     = idx_w[NW-1:0];
  assign rot_w = rotl(gnt_w, REQS);

  assign beat = (|gnt) & bus.rdy;
  assign eot  = beat & (|(gnt & bus.last));

  // Credit run: consecutive transactions by the port currently holding top.
  assign w_k     = bus.weight[k*WW +: WW];
  assign w_eff   = (w_k == '0) ? ONE_C : {1'b0, w_k};
  assign c       = (gnt == top_reg) ? ({1'b0, cnt_reg} + ONE_C) : ONE_C;
  assign advance = IS_RR || (c >= w_eff);

  assign unused_bits = &{1'b0, idx_w[IDX_W-1:NW], rot_w[MAX_REQS-1:REQS]};

  assign bus.gnt  = gnt;
  assign bus.num  = k;
  assign bus.lock = lck_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lck_reg <= 1'b0;
      own_reg <= '0;
      top_reg <= TOP_RST;
      cnt_reg <= '0;
    end else begin
      // An owner that drops its request keeps the lock until it returns.
      lck_reg <= (lck_reg & ~(|gnt)) | ((|gnt) & ~eot);
      if (|gnt) own_reg <= gnt;
      if (eot && !IS_FP) begin
        if (advance) begin
          top_reg <= rot_w[REQS-1:0];
          cnt_reg <= '0;
        end else begin
          top_reg <= gnt;
          cnt_reg <= c[WW-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_wrr_arbitrator.sv
// Drives FP, RR and WRR arbiters with one shared stimulus stream and compares
// each against an index-based reference model of the arbitration rules.
module tb_wrr_arbitrator;
  import arb_pkg::*;

  localparam int REQS = 4;
  localparam int WW   = 4;
  localparam int NS   = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [REQS-1:0]     req = '0;
  logic [REQS-1:0]     last = '0;
  logic                rdy = 1'b0;
  logic [REQS*WW-1:0]  weight = 16'h1111;

  logic [REQS-1:0]     gnt_o [NS];
  logic [1:0]          num_o [NS];
  logic                lock_o [NS];

  int n_chk = 0;
  int n_fail = 0;

  int m_ptr [NS];
  int m_cred [NS];
  int m_own [NS];
  bit m_lck [NS];

  always #5 clk = ~clk;

  wrr_arbitrator_if #(.REQS(REQS), .WW(WW)) bus [NS] ();

  for (genvar g = 0; g < NS; g++) begin : g_dut
    localparam string SCH = (g == 0) ? ARB_FP : ((g == 1) ? ARB_RR : ARB_WRR);
    assign bus[g].req    = req;
    assign bus[g].last   = last;
    assign bus[g].weight = weight;
    assign bus[g].rdy    = rdy;
    assign gnt_o[g]      = bus[g].gnt;
    assign num_o[g]      = bus[g].num;
    assign lock_o[g]     = bus[g].lock;

    wrr_arbitrator #(.REQS(REQS), .SCHEME(SCH), .WW(WW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic string sname(input int s);
    return (s == 0) ? "fp" : ((s == 1) ? "rr" : "wrr");
  endfunction

  // Index of the requester that should hold the grant now, or -1.
  function automatic int model_gnt(input int s);
    int start;
    int idx;
    if (m_lck[s]) return req[m_own[s]] ? m_own[s] : -1;
    start = (s == 0) ? 0 : m_ptr[s];
    for (int i = 0; i < REQS; i++) begin
      idx = (start + i) % REQS;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0; m_cred[s] = 0; m_own[s] = 0; m_lck[s] = 1'b0;
    end
  endfunction

  // Applies the clock edge that just happened, using the inputs that were held across it.
  function automatic void model_advance();
    int g;
    int run;
    int wl;
    bit done;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int s = 0; s < NS; s++) begin
      g = model_gnt(s);
      if (g >= 0) begin
        done = rdy && last[g];
        if (done && s != 0) begin
          run = (g == m_ptr[s]) ? m_cred[s] + 1 : 1;
          wl  = int'(weight[g*WW +: WW]);
          if (wl == 0) wl = 1;
          if (s == 1 || run >= wl) begin
            m_ptr[s] = (g + 1) % REQS; m_cred[s] = 0;
          end else begin
            m_ptr[s] = g; m_cred[s] = run;
          end
        end
        m_lck[s] = !done;
        m_own[s] = g;
      end
    end
  endfunction

  task automatic compare_model();
    int g;
    for (int s = 0; s < NS; s++) begin
      g = model_gnt(s);
      check_val({sname(s), "_gnt"},  32'(gnt_o[s]),  (g < 0) ? 32'd0 : (32'd1 << g));
      check_val({sname(s), "_num"},  32'(num_o[s]),  (g < 0) ? 32'd0 : 32'(g));
      check_val({sname(s), "_lock"}, 32'(lock_o[s]), 32'(m_lck[s]));
    end
  endtask

  task automatic step(input logic [REQS-1:0] r, input logic [REQS-1:0] l,
                      input logic rd, input logic rs);
    @(negedge clk);
    model_advance();
    req = r; last = l; rdy = rd; reset = rs;
    #1;
    compare_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_num [8];
    exp_num = '{0, 3, 3, 3, 0, 3, 3, 3};

    req = 4'b1111; last = 4'b1111; rdy = 1'b1; reset = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state with all requests up, then FP must keep port 0.
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    check_val("rst_gnt",  32'(gnt_o[2]), 32'h1);
    check_val("rst_num",  32'(num_o[2]), 32'h0);
    check_val("rst_lock", 32'(lock_o[2]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b1111, 1'b1, 1'b1);
      check_val("fp_hold", 32'(gnt_o[0]), 32'h1);
    end

    // RR fairness rotation.
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b1111, 1'b1, 1'b1);
      check_val("rr_seq", 32'(gnt_o[1]), 32'd1 << (i % 4));
    end

    // Three-beat locked transaction with rdy stalls.
    step(4'b0101, 4'b0000, 1'b1, 1'b0);
    step(4'b0101, 4'b0000, 1'b1, 1'b1);
    check_val("lk_b1", 32'(gnt_o[1]), 32'h1);
    step(4'b0101, 4'b0000, 1'b0, 1'b1);
    check_val("lk_lock", 32'(lock_o[1]), 32'h1);
    step(4'b0101, 4'b0000, 1'b1, 1'b1);
    step(4'b0101, 4'b0000, 1'b0, 1'b1);
    check_val("lk_stall", 32'(gnt_o[1]), 32'h1);
    step(4'b0101, 4'b0001, 1'b1, 1'b1);
    step(4'b0101, 4'b0000, 1'b0, 1'b1);
    check_val("lk_next", 32'(gnt_o[1]), 32'h4);

    // Weighted rotation, then the same pattern with port 0 weight zero.
    for (int pass = 0; pass < 2; pass++) begin
      weight = (pass == 0) ? 16'h3111 : 16'h3110;
      step(4'b1001, 4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
        step(4'b1001, 4'b1111, 1'b1, 1'b1);
        check_val("wrr_seq", 32'(num_o[2]), 32'(exp_num[i]));
      end
    end

    // Stall before the first beat; owner drops and re-raises its request.
    weight = 16'h3111;
    step(4'b0010, 4'b0000, 1'b0, 1'b0);
    step(4'b0010, 4'b0000, 1'b0, 1'b1);
    step(4'b0011, 4'b0000, 1'b0, 1'b1);
    check_val("st_gnt",  32'(gnt_o[2]), 32'h2);
    check_val("st_lock", 32'(lock_o[2]), 32'h1);
    step(4'b0001, 4'b0000, 1'b0, 1'b1);
    check_val("st_drop", 32'(gnt_o[2]), 32'h0);
    check_val("st_dlck", 32'(lock_o[2]), 32'h1);
    step(4'b0011, 4'b0010, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    check_val("st_free", 32'(lock_o[2]), 32'h0);

    // Reset in the middle of a credited, locked WRR burst.
    step(4'b1000, 4'b1111, 1'b1, 1'b0);
    step(4'b1000, 4'b1111, 1'b1, 1'b1);
    step(4'b1000, 4'b1111, 1'b1, 1'b1);
    step(4'b1000, 4'b0000, 1'b1, 1'b1);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 1'b1);
    check_val("mr_gnt",  32'(gnt_o[2]), 32'h1);
    check_val("mr_lock", 32'(lock_o[2]), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) weight = 16'($urandom);
      step(REQS'($urandom),
           ($urandom_range(0, 1) == 1) ? 4'b1111 : REQS'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
